// File: rtl/fifo_rptr_empty.sv
// fifo_rptr_empty
// ---------------
// Read-side pointer and empty-flag stage of an asynchronous FIFO. Everything
// here runs in the read clock domain. The write pointer arrives already
// synchronised (rq2_wptr, Gray coded). This block produces the following:
//   - the registered Gray read pointer for the opposite-domain synchroniser,
//   - the binary RAM read address,
//   - the empty, almost-empty, fill-level and sticky underflow status.
//
// Handshake: a pop is accepted in any cycle where rd_en is high and the
// registered empty flag is low (rd_fire). rd_en is a request only. When it
// arrives while empty, the pop is dropped and the underflow flag is set.
//
// Ports
//   clk          in   read-domain clock
//   rst_n        in   synchronous active-low reset
//   rd_en        in   pop request
//   clr_err      in   clears the sticky underflow flag
//   rq2_wptr     in   synchronised Gray write pointer [PTR_WIDTH:0]
//   rptr         out  registered Gray read pointer   [PTR_WIDTH:0]
//   raddr        out  binary RAM read address        [PTR_WIDTH-1:0]
//   rd_fire      out  accepted pop / RAM read enable
//   empty        out  registered empty flag
//   almost_empty out  registered level <= AE_THRESH
//   rd_level     out  registered conservative fill level [PTR_WIDTH:0]
//   underflow    out  sticky pop-while-empty error

module fifo_rptr_empty #(
    parameter int PTR_WIDTH = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en,
    input  logic                 clr_err,
    input  logic [PTR_WIDTH:0]   rq2_wptr,
    output logic [PTR_WIDTH:0]   rptr,
    output logic [PTR_WIDTH-1:0] raddr,
    output logic                 rd_fire,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   rd_level,
    output logic                 underflow
);

    localparam logic [PTR_WIDTH:0] AE_T = (PTR_WIDTH+1)'(AE_THRESH);

    logic [PTR_WIDTH:0] rbin;
    logic [PTR_WIDTH:0] rbin_next;
    logic [PTR_WIDTH:0] rgray_next;
    logic [PTR_WIDTH:0] wbin;
    logic [PTR_WIDTH:0] level_next;

    // Gate the pop with the registered empty flag, so the pop decision
    // never depends on the same-cycle synchroniser output.
    assign rd_fire = rd_en & ~empty;

    assign rbin_next  = rbin + {{PTR_WIDTH{1'b0}}, rd_fire};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign raddr      = rbin[PTR_WIDTH-1:0];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        wbin[PTR_WIDTH] = rq2_wptr[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ rq2_wptr[i];
        end
    end

    // The synchronised write pointer lags, so this level can only underestimate.
    assign level_next = wbin - rbin_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rbin         <= '0;
            rptr         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rptr         <= rgray_next;
            // Comparing against the next-state pointer lets the last pop
            // raise empty on the same edge that advances the pointer.
            empty        <= (rgray_next == rq2_wptr);
            almost_empty <= (level_next <= AE_T);
            rd_level     <= level_next;
            // A new underflow takes priority over a same-cycle clear.
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed testbench for fifo_rptr_empty (PTR_WIDTH=4, AE_THRESH=2).

module tb_fifo_rptr_empty;

    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          rd_en;
    logic          clr_err;
    logic [PW:0]   rq2_wptr;
    logic [PW:0]   rptr;
    logic [PW-1:0] raddr;
    logic          rd_fire;
    logic          empty;
    logic          almost_empty;
    logic [PW:0]   rd_level;
    logic          underflow;

    int n_checks;
    int n_errors;

    fifo_rptr_empty #(.PTR_WIDTH(PW), .AE_THRESH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .rq2_wptr     (rq2_wptr),
        .rptr         (rptr),
        .raddr        (raddr),
        .rd_fire      (rd_fire),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .underflow    (underflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver: advance one clock edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW:0] gray(input int b);
        logic [PW:0] v;
        v = PW'(b) ;
        v = (PW+1)'(b);
        return (v >> 1) ^ v;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_rptr"},  32'(rptr), 0);
        check({tag, "_raddr"}, 32'(raddr), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_ae"},    32'(almost_empty), 1);
        check({tag, "_level"}, 32'(rd_level), 0);
        check({tag, "_uf"},    32'(underflow), 0);
        check({tag, "_fire"},  32'(rd_fire), 0);
    endtask

    logic [PW:0] prev_rptr;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        rd_en    = 1'b1;
        clr_err  = 1'b0;
        rq2_wptr = 5'b00011;

        // Reset held for two edges with a pop request and a nonzero wptr
        step();
        step();
        check_reset_vals("rst");

        // Release reset
        rd_en    = 1'b0;
        rq2_wptr = 5'b00000;
        rst_n    = 1'b1;
        step();
        check("rel_empty", 32'(empty), 1);
        check("rel_level", 32'(rd_level), 0);

        // Fill: Gray 0 -> 1 -> 3 -> 2
        rq2_wptr = 5'b00001; step();
        check("fill1_empty", 32'(empty), 0);
        check("fill1_level", 32'(rd_level), 1);
        check("fill1_ae",    32'(almost_empty), 1);
        rq2_wptr = 5'b00011; step();
        check("fill2_level", 32'(rd_level), 2);
        check("fill2_ae",    32'(almost_empty), 1);
        rq2_wptr = 5'b00010; step();
        check("fill3_level", 32'(rd_level), 3);
        check("fill3_empty", 32'(empty), 0);
        check("fill3_ae",    32'(almost_empty), 0);

        // Drain three entries
        rd_en = 1'b1;
        #1;
        check("pop0_fire",  32'(rd_fire), 1);
        check("pop0_raddr", 32'(raddr), 0);
        step();
        check("pop1_rptr",  32'(rptr), 32'b00001);
        check("pop1_raddr", 32'(raddr), 1);
        check("pop1_level", 32'(rd_level), 2);
        check("pop1_ae",    32'(almost_empty), 1);
        check("pop1_empty", 32'(empty), 0);
        step();
        check("pop2_rptr",  32'(rptr), 32'b00011);
        check("pop2_raddr", 32'(raddr), 2);
        check("pop2_level", 32'(rd_level), 1);
        check("pop2_empty", 32'(empty), 0);
        step();
        check("pop3_rptr",  32'(rptr), 32'b00010);
        check("pop3_raddr", 32'(raddr), 3);
        check("pop3_level", 32'(rd_level), 0);
        check("pop3_empty", 32'(empty), 1);

        // Underflow: rd_en still high while empty
        check("uf_fire", 32'(rd_fire), 0);
        step();
        check("uf_set",  32'(underflow), 1);
        check("uf_rptr", 32'(rptr), 32'b00010);
        rd_en = 1'b0;
        step();
        check("uf_hold", 32'(underflow), 1);
        clr_err = 1'b1;
        step();
        check("uf_clr", 32'(underflow), 0);
        rd_en = 1'b1;
        step();
        check("uf_set_wins", 32'(underflow), 1);
        check("uf_set_rptr", 32'(rptr), 32'b00010);
        rd_en = 1'b0;
        step();
        check("uf_clr2", 32'(underflow), 0);
        clr_err = 1'b0;

        // Wrap: restart from zero, then write one and pop one, 32 times
        rst_n = 1'b0;
        rq2_wptr = 5'b00000;
        step();
        rst_n = 1'b1;
        step();
        check("wrap_start_rptr", 32'(rptr), 0);
        for (int i = 0; i < 32; i++) begin
            prev_rptr = rptr;
            rq2_wptr  = gray(i + 1);
            rd_en     = 1'b0;
            step();
            check("wrap_nempty", 32'(empty), 0);
            rd_en = 1'b1;
            step();
            check("wrap_rptr",   32'(rptr), 32'(gray(i + 1)));
            check("wrap_onebit", $countones(prev_rptr ^ rptr), 1);
            check("wrap_empty",  32'(empty), 1);
            if (i == 30) check("wrap_31", 32'(rptr), 32'b10000);
        end
        rd_en = 1'b0;
        check("wrap_end_rptr",  32'(rptr), 0);
        check("wrap_end_empty", 32'(empty), 1);

        // Full level: rbin = 0, wptr = Gray(16)
        rq2_wptr = 5'b11000;
        step();
        check("full_level", 32'(rd_level), 16);
        check("full_empty", 32'(empty), 0);
        check("full_ae",    32'(almost_empty), 0);

        // Mid-operation reset at level 5
        rq2_wptr = 5'b00111;
        step();
        check("mid_level5", 32'(rd_level), 5);
        rd_en = 1'b1;
        rst_n = 1'b0;
        step();
        check_reset_vals("mid_rst");
        rst_n = 1'b1;
        rd_en = 1'b0;
        step();
        check("mid_rel_level", 32'(rd_level), 5);
        check("mid_rel_empty", 32'(empty), 0);
        check("mid_rel_ae",    32'(almost_empty), 0);
        check("mid_rel_rptr",  32'(rptr), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
